// File: rtl/ldtu_mode_ctrl_if.sv
// Command handshake between the slow/fast control interface and the
// LiTE-DTU mode sequencer.
//   cmd_valid : command present, held by the source until accepted
//   cmd       : 4-bit command code
//   cmd_ready : sequencer can accept (IDLE only)
// master = command source, slave = sequencer.
interface ldtu_mode_ctrl_if;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/ldtu_mode_ctrl.sv
// Fast-command sequencer for the LiTE-DTU 160 MHz datapath.
// Decodes 4-bit commands and drives the DTU mode lines. All outputs are
// registered; an accept at edge k takes effect after edge k.
// Ports:
//   clk         160 MHz clock
//   rst_n       asynchronous reset, active low
//   cmd_if      command handshake (cmd_valid, cmd, cmd_ready)
//   orbit       orbit marker, 1-cycle pulse
//   dtu_rst     datapath reset request, RST_LEN cycles
//   calib_busy  orbit-aligned calibration window, CAL_LEN cycles
//   test_enable ATU test-pattern select (level)
//   fallback    encoder fallback select (level)
//   handshake   sync window to control unit, SYNC_LEN cycles
//   cmd_err     1-cycle pulse: illegal code or CALIB orbit timeout
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | ready for a command, level commands applied here
// RESET    | dtu_rst asserted, counting down RST_LEN
// WAIT_ORB | CALIB accepted, counting up until orbit or timeout
// CALIB    | calib_busy asserted, counting down CAL_LEN
// SYNC     | handshake asserted, counting down SYNC_LEN
module ldtu_mode_ctrl #(
  parameter int CNT_W    = 8,
  parameter int RST_LEN  = 4,
  parameter int CAL_LEN  = 16,
  parameter int SYNC_LEN = 32,
  parameter int ORB_TMO  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ldtu_mode_ctrl_if.slave      cmd_if,
  input  logic                 orbit,
  output logic                 dtu_rst,
  output logic                 calib_busy,
  output logic                 test_enable,
  output logic                 fallback,
  output logic                 handshake,
  output logic                 cmd_err
);

  localparam logic [3:0] C_NOP      = 4'h0;
  localparam logic [3:0] C_DTU_RST  = 4'h1;
  localparam logic [3:0] C_CALIB    = 4'h2;
  localparam logic [3:0] C_TEST_ON  = 4'h3;
  localparam logic [3:0] C_TEST_OFF = 4'h4;
  localparam logic [3:0] C_FB_ON    = 4'h5;
  localparam logic [3:0] C_FB_OFF   = 4'h6;
  localparam logic [3:0] C_SYNC     = 4'h7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT_ORB,
    S_CALIB,
    S_SYNC
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cmd_ready_q;

  assign cmd_if.cmd_ready = cmd_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cmd_ready_q <= 1'b1;
      dtu_rst     <= 1'b0;
      calib_busy  <= 1'b0;
      test_enable <= 1'b0;
      fallback    <= 1'b0;
      handshake   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_if.cmd_valid) begin
            case (cmd_if.cmd)
              C_NOP: ;
              C_DTU_RST: begin
                // Top-level reset is gated by TEST/CAL, so clear them here.
                state       <= S_RESET;
                cnt         <= CNT_W'(RST_LEN - 1);
                cmd_ready_q <= 1'b0;
                dtu_rst     <= 1'b1;
                test_enable <= 1'b0;
                fallback    <= 1'b0;
                calib_busy  <= 1'b0;
              end
              C_CALIB: begin
                state       <= S_WAIT_ORB;
                cnt         <= '0;
                cmd_ready_q <= 1'b0;
              end
              C_TEST_ON:  test_enable <= 1'b1;
              C_TEST_OFF: test_enable <= 1'b0;
              C_FB_ON:    fallback    <= 1'b1;
              C_FB_OFF:   fallback    <= 1'b0;
              C_SYNC: begin
                state       <= S_SYNC;
                cnt         <= CNT_W'(SYNC_LEN - 1);
                cmd_ready_q <= 1'b0;
                handshake   <= 1'b1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        S_RESET: begin
          if (cnt == '0) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
            dtu_rst     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT_ORB: begin
          // Orbit wins over timeout on the last waiting cycle.
          if (orbit) begin
            state       <= S_CALIB;
            cnt         <= CNT_W'(CAL_LEN - 1);
            calib_busy  <= 1'b1;
            test_enable <= 1'b0;
          end else if (cnt == CNT_W'(ORB_TMO - 1)) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cmd_ready_q <= 1'b1;
            cmd_err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CALIB: begin
          if (cnt == '0) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
            calib_busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SYNC: begin
          if (cnt == '0) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
            handshake   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          cmd_ready_q <= 1'b1;
          dtu_rst     <= 1'b0;
          calib_busy  <= 1'b0;
          handshake   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldtu_mode_ctrl.sv
// Directed bench for ldtu_mode_ctrl: reset, level commands, DTU reset pulse,
// orbit-aligned calibration, orbit timeout, illegal code and held SYNC.
module tb_ldtu_mode_ctrl;

  logic clk;
  logic rst_n;
  logic orbit;
  logic dtu_rst, calib_busy, test_enable, fallback, handshake, cmd_err;

  int tests_run = 0;
  int tests_failed = 0;
  int flag;

  ldtu_mode_ctrl_if cmd_if ();

  ldtu_mode_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_if      (cmd_if),
    .orbit       (orbit),
    .dtu_rst     (dtu_rst),
    .calib_busy  (calib_busy),
    .test_enable (test_enable),
    .fallback    (fallback),
    .handshake   (handshake),
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    orbit = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd = 4'h0;
    #12;
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_outs", {26'd0, dtu_rst, calib_busy, test_enable, fallback, handshake, cmd_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Level commands on consecutive cycles.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd = 4'h3;
    tick();
    chk("lvl_test_on", 32'(test_enable), 32'd1);
    chk("lvl_ready1", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd = 4'h5;
    tick();
    chk("lvl_fb_on", {30'd0, test_enable, fallback}, 32'd3);
    cmd_if.cmd = 4'h4;
    tick();
    chk("lvl_test_off", {30'd0, test_enable, fallback}, 32'd1);
    chk("lvl_ready3", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd = 4'h5;   // repeat of a set level
    tick();
    chk("lvl_fb_repeat", {30'd0, test_enable, fallback}, 32'd1);

    // DTU reset with both levels set.
    cmd_if.cmd = 4'h3;
    tick();
    cmd_if.cmd = 4'h1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("rst_pulse_start", {29'd0, dtu_rst, test_enable, fallback}, 32'd4);
    chk("rst_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    flag = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dtu_rst !== 1'b1 || cmd_if.cmd_ready !== 1'b0) flag = 1;
    end
    chk("rst_pulse_hold", 32'(flag), 32'd0);
    tick();
    chk("rst_pulse_end", {30'd0, dtu_rst, cmd_if.cmd_ready}, 32'd1);

    // CALIB with orbit 10 cycles after accept; orbit on accept cycle ignored.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd = 4'h3;
    tick();
    cmd_if.cmd = 4'h2;
    orbit = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    orbit = 1'b0;
    chk("cal_wait_busy", {30'd0, calib_busy, cmd_if.cmd_ready}, 32'd0);
    repeat (9) tick();
    chk("cal_wait_still", {29'd0, calib_busy, cmd_if.cmd_ready, test_enable}, 32'd1);
    orbit = 1'b1;
    tick();
    orbit = 1'b0;
    chk("cal_busy_start", {30'd0, calib_busy, test_enable}, 32'd2);
    flag = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (calib_busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) flag = 1;
    end
    chk("cal_busy_hold", 32'(flag), 32'd0);
    tick();
    chk("cal_busy_end", {30'd0, calib_busy, cmd_if.cmd_ready}, 32'd1);

    // CALIB without orbit: timeout after 255 cycles.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd = 4'h2;
    tick();
    cmd_if.cmd_valid = 1'b0;
    flag = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (calib_busy !== 1'b0 || cmd_err !== 1'b0 || cmd_if.cmd_ready !== 1'b0) flag = 1;
    end
    chk("tmo_wait", 32'(flag), 32'd0);
    tick();
    chk("tmo_err", {29'd0, cmd_err, calib_busy, cmd_if.cmd_ready}, 32'd5);
    tick();
    chk("tmo_err_pulse", {30'd0, cmd_err, cmd_if.cmd_ready}, 32'd1);

    // Illegal code.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd = 4'hA;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("ill_err", {30'd0, cmd_err, cmd_if.cmd_ready}, 32'd3);
    tick();
    chk("ill_err_pulse", 32'(cmd_err), 32'd0);

    // SYNC held: second accept only after the 32-cycle window.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd = 4'h7;
    tick();
    chk("sync_start", {30'd0, handshake, cmd_if.cmd_ready}, 32'd2);
    flag = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (handshake !== 1'b1 || cmd_if.cmd_ready !== 1'b0 || cmd_err !== 1'b0) flag = 1;
    end
    chk("sync_hold", 32'(flag), 32'd0);
    tick();
    chk("sync_end", {30'd0, handshake, cmd_if.cmd_ready}, 32'd1);
    tick();
    chk("sync_reaccept", {30'd0, handshake, cmd_if.cmd_ready}, 32'd2);
    repeat (5) tick();

    // Asynchronous reset mid-SYNC.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hs", 32'(handshake), 32'd0);
    chk("async_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("async_outs", {26'd0, dtu_rst, calib_busy, test_enable, fallback, handshake, cmd_err}, 32'd0);
    cmd_if.cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {30'd0, handshake, cmd_if.cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
